// File: rtl/bcd_press_counter.sv
`timescale 1ns/1ps
// bcd_press_counter: debounced pushbutton press counter with a packed BCD count and a
// multiplexed digit scanner. Optional build macro: LEADING_ZERO_BLANK_EN (blank leading zeros).
module bcd_press_counter #(
    parameter int NUM_DIGITS      = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SCAN_CYCLES     = 50000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    btn_raw,
    input  logic                    clr,
    output logic [4*NUM_DIGITS-1:0] count_bcd,
    output logic [3:0]              digit_bcd,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    press_pulse,
    output logic                    overflow
);

    localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int SCAN_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam int IDX_W  = $clog2(NUM_DIGITS);

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CYCLES - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    // ------------------------------------------------------------------
    // Input synchronizer
    // ------------------------------------------------------------------
    logic sync_meta;
    logic sync_q;

    // NOTE: sequential state is always written with <= so every flop samples
    // the pre-edge value of its neighbours, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= 1'b0;
            sync_q    <= 1'b0;
        end else begin
            sync_meta <= btn_raw;
            sync_q    <= sync_meta;
        end
    end

    // ------------------------------------------------------------------
    // Debouncer and press edge detector
    // ------------------------------------------------------------------
    logic [DEB_W-1:0] deb_cnt;
    logic             stable_q;
    logic             stable_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_cnt  <= '0;
            stable_q <= 1'b0;
        end else if (sync_q == stable_q) begin
            deb_cnt <= '0;
        end else if (deb_cnt == DEB_LAST) begin
            deb_cnt  <= '0;
            stable_q <= sync_q;
        end else begin
            deb_cnt <= deb_cnt + DEB_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_d    <= 1'b0;
            press_pulse <= 1'b0;
        end else begin
            stable_d    <= stable_q;
            press_pulse <= stable_q & ~stable_d;
        end
    end

    // ------------------------------------------------------------------
    // BCD counter
    // ------------------------------------------------------------------
    logic [4*NUM_DIGITS-1:0] count_q;
    logic [4*NUM_DIGITS-1:0] count_inc;
    logic [4*NUM_DIGITS-1:0] count_next;
    logic                    carry;
    logic                    all_nines;
    logic                    wrap_next;

    // NOTE: every variable of a combinational block is given a default before
    // any branch, so no path can leave it unassigned and infer a latch.
    always_comb begin
        count_inc = count_q;
        carry     = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (carry) begin
                // A digit at or above 9 rolls to 0, so no digit can ever exceed 9.
                if (count_q[4*i +: 4] >= 4'd9) begin
                    count_inc[4*i +: 4] = 4'd0;
                end else begin
                    count_inc[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
                    carry               = 1'b0;
                end
            end
        end
        all_nines = carry;

        count_next = count_q;
        wrap_next  = 1'b0;
        if (clr) begin
            count_next = '0;
        end else if (press_pulse) begin
            count_next = count_inc;
            wrap_next  = all_nines;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= '0;
            overflow <= 1'b0;
        end else begin
            count_q  <= count_next;
            overflow <= wrap_next;
        end
    end

    assign count_bcd = count_q;

    // ------------------------------------------------------------------
    // Digit scanner
    // ------------------------------------------------------------------
    logic [SCAN_W-1:0] scan_timer;
    logic [SCAN_W-1:0] scan_timer_next;
    logic [IDX_W-1:0]  scan_idx;
    logic [IDX_W-1:0]  scan_idx_next;

    always_comb begin
        scan_timer_next = scan_timer + SCAN_W'(1);
        scan_idx_next   = scan_idx;
        if (scan_timer == SCAN_LAST) begin
            scan_timer_next = '0;
            scan_idx_next   = (scan_idx == IDX_LAST) ? '0 : scan_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_timer <= '0;
            scan_idx   <= '0;
        end else begin
            scan_timer <= scan_timer_next;
            scan_idx   <= scan_idx_next;
        end
    end

    always_comb begin
        digit_sel = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            digit_sel[i] = (scan_idx != IDX_W'(i));
        end
    end

    // digit_bcd is registered from the next count and next index, so it lines up
    // with count_bcd and digit_sel in the same cycle.
    logic [3:0] digit_next;

`ifdef LEADING_ZERO_BLANK_EN
    logic upper_zero;
    logic blank;
`endif

    always_comb begin
        digit_next = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (scan_idx_next == IDX_W'(i)) begin
                digit_next = count_next[4*i +: 4];
            end
        end
`ifdef LEADING_ZERO_BLANK_EN
        upper_zero = 1'b1;
        blank      = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            upper_zero = upper_zero & (count_next[4*i +: 4] == 4'd0);
            if ((scan_idx_next == IDX_W'(i)) && upper_zero) begin
                blank = 1'b1;
            end
        end
        if (blank) begin
            digit_next = 4'hF;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_bcd <= 4'd0;
        end else begin
            digit_bcd <= digit_next;
        end
    end

endmodule

// File: tb/tb_bcd_press_counter.sv
`timescale 1ns/1ps
// tb_bcd_press_counter: directed and randomized checks of bcd_press_counter against a
// behavioural model (integer count, arithmetic scan phase). Define LEADING_ZERO_BLANK_EN to test blanking.
module tb_bcd_press_counter;

    localparam int N    = 4;
    localparam int D    = 4;
    localparam int S    = 3;
    localparam int MAXV = 10000;

    logic         clk     = 1'b0;
    logic         rst_n   = 1'b0;
    logic         btn_raw = 1'b0;
    logic         clr     = 1'b0;
    logic [4*N-1:0] count_bcd;
    logic [3:0]   digit_bcd;
    logic [N-1:0] digit_sel;
    logic         press_pulse;
    logic         overflow;

    int n_cmp = 0;
    int n_bad = 0;

    bcd_press_counter #(
        .NUM_DIGITS      (N),
        .DEBOUNCE_CYCLES (D),
        .SCAN_CYCLES     (S)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_raw     (btn_raw),
        .clr         (clr),
        .count_bcd   (count_bcd),
        .digit_bcd   (digit_bcd),
        .digit_sel   (digit_sel),
        .press_pulse (press_pulse),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    typedef struct {
        bit s1;      // raw level seen one edge ago
        bit s2;      // raw level seen two edges ago (the usable input)
        bit stable;
        bit rose;    // stable level went 0->1 at the last edge
        bit pulse;
        bit ov;
        int run;     // consecutive edges where the usable input disagreed with stable
        int count;   // count as a plain integer 0..MAXV-1
        int t;       // edges since reset release
    } model_t;

    model_t m;
    bit     pre_en  = 1'b0;
    int     pre_val = 0;

    function automatic model_t model_step(model_t cur, bit raw, bit c, bit p_en, int p_val);
        model_t nx;
        if (p_en) cur.count = p_val;
        nx       = cur;
        nx.s1    = raw;
        nx.s2    = cur.s1;
        nx.rose  = 1'b0;
        if (cur.s2 == cur.stable) begin
            nx.run = 0;
        end else begin
            nx.run = cur.run + 1;
            if (nx.run == D) begin
                nx.run    = 0;
                nx.stable = cur.s2;
                nx.rose   = cur.s2;
            end
        end
        nx.pulse = cur.rose;
        nx.ov    = 1'b0;
        if (c) begin
            nx.count = 0;
        end else if (cur.pulse) begin
            nx.count = (cur.count + 1) % MAXV;
            nx.ov    = (cur.count == MAXV - 1);
        end
        nx.t = cur.t + 1;
        return nx;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '{default: 0};
        else        m <= model_step(m, btn_raw, clr, pre_en, pre_val);
    end

    function automatic int pow10(int k);
        int r = 1;
        for (int i = 0; i < k; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [4*N-1:0] exp_bcd(int v);
        logic [4*N-1:0] r = '0;
        for (int i = 0; i < N; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
        return r;
    endfunction

    function automatic int exp_idx(int t);
        return (t / S) % N;
    endfunction

    function automatic logic [N-1:0] exp_sel(int t);
        logic [N-1:0] r = '1;
        r[exp_idx(t)] = 1'b0;
        return r;
    endfunction

    function automatic logic [3:0] exp_digit(int v, int t);
        int idx = exp_idx(t);
        logic [3:0] d = 4'((v / pow10(idx)) % 10);
`ifdef LEADING_ZERO_BLANK_EN
        if (idx > 0 && v < pow10(idx)) d = 4'hF;
`endif
        return d;
    endfunction

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        btn_raw = 1'b0;
        clr     = 1'b0;
        pre_en  = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Loads a count into the DUT register and the model over one idle clock edge.
    task automatic preload(int v);
        force dut.count_q = exp_bcd(v);
        pre_en  = 1'b1;
        pre_val = v;
        @(negedge clk);
        release dut.count_q;
        pre_en = 1'b0;
    endtask

    task automatic press_once();
        btn_raw = 1'b1;
        repeat (D + 3) @(negedge clk);
        btn_raw = 1'b0;
        repeat (D + 3) @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        btn_raw = 1'b1;
        clr     = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (count_bcd !== 16'h0000) begin n_bad++; $display("FAIL reset_count: got %h want 0000", count_bcd); end
        n_cmp++; if (digit_bcd !== 4'h0) begin n_bad++; $display("FAIL reset_digit: got %h want 0", digit_bcd); end
        n_cmp++; if (digit_sel !== 4'b1110) begin n_bad++; $display("FAIL reset_sel: got %b want 1110", digit_sel); end
        n_cmp++; if (press_pulse !== 1'b0) begin n_bad++; $display("FAIL reset_pulse: got %b want 0", press_pulse); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b want 0", overflow); end
        btn_raw = 1'b0;
        clr     = 1'b0;
        rst_n   = 1'b1;
    endtask

    task automatic test_glitch_press();
        logic [21:0] pat = 22'b0000000000_11111111_0_111;
        int pulses = 0;
        do_reset();
        for (int k = 0; k < 22; k++) begin
            btn_raw = pat[k];
            @(negedge clk);
            if (press_pulse === 1'b1) pulses++;
            n_cmp++; if (press_pulse !== m.pulse) begin n_bad++; $display("FAIL glitch_pulse cyc %0d: got %b want %b", k, press_pulse, m.pulse); end
        end
        n_cmp++; if (pulses != 1) begin n_bad++; $display("FAIL glitch_pulse_count: got %0d want 1", pulses); end
        n_cmp++; if (count_bcd !== 16'h0001) begin n_bad++; $display("FAIL glitch_count: got %h want 0001", count_bcd); end
    endtask

    task automatic test_hold_through_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        btn_raw = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            n_cmp++;
            if (press_pulse !== (k == D + 3)) begin
                n_bad++; $display("FAIL hold_latency cyc %0d: got %b want %b", k, press_pulse, (k == D + 3));
            end
        end
        n_cmp++; if (count_bcd !== 16'h0001) begin n_bad++; $display("FAIL hold_count: got %h want 0001", count_bcd); end
        btn_raw = 1'b0;
        repeat (D + 3) @(negedge clk);
    endtask

    task automatic test_wrap();
        int ov_seen = 0;
        logic [15:0] at_ov = 16'hFFFF;
        do_reset();
        preload(9999);
        n_cmp++; if (count_bcd !== 16'h9999) begin n_bad++; $display("FAIL wrap_preload: got %h want 9999", count_bcd); end
        btn_raw = 1'b1;
        for (int k = 0; k < 2 * D + 8; k++) begin
            if (k == D + 3) btn_raw = 1'b0;
            @(negedge clk);
            n_cmp++; if (overflow !== m.ov) begin n_bad++; $display("FAIL wrap_ovf cyc %0d: got %b want %b", k, overflow, m.ov); end
            if (overflow === 1'b1) begin ov_seen++; at_ov = count_bcd; end
        end
        n_cmp++; if (ov_seen != 1) begin n_bad++; $display("FAIL wrap_ovf_count: got %0d want 1", ov_seen); end
        n_cmp++; if (at_ov !== 16'h0000) begin n_bad++; $display("FAIL wrap_ovf_align: got %h want 0000", at_ov); end
        n_cmp++; if (count_bcd !== 16'h0000) begin n_bad++; $display("FAIL wrap_count: got %h want 0000", count_bcd); end
    endtask

    task automatic test_carry();
        do_reset();
        preload(19);
        press_once();
        n_cmp++; if (count_bcd !== 16'h0020) begin n_bad++; $display("FAIL carry_19: got %h want 0020", count_bcd); end
        for (int k = 0; k < 10; k++) press_once();
        n_cmp++; if (count_bcd !== 16'h0030) begin n_bad++; $display("FAIL carry_30: got %h want 0030", count_bcd); end
        n_cmp++; if (count_bcd !== exp_bcd(m.count)) begin n_bad++; $display("FAIL carry_model: got %h want %h", count_bcd, exp_bcd(m.count)); end
    endtask

    task automatic test_clr_priority(int start);
        int guard = 0;
        do_reset();
        preload(start);
        btn_raw = 1'b1;
        while (m.pulse != 1'b1 && guard < 30) begin
            @(negedge clk);
            guard++;
        end
        n_cmp++; if (press_pulse !== 1'b1) begin n_bad++; $display("FAIL clr_pulse_seen start %0d: got %b want 1", start, press_pulse); end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        n_cmp++; if (count_bcd !== 16'h0000) begin n_bad++; $display("FAIL clr_count start %0d: got %h want 0000", start, count_bcd); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL clr_ovf start %0d: got %b want 0", start, overflow); end
        btn_raw = 1'b0;
        repeat (D + 4) @(negedge clk);
        n_cmp++; if (count_bcd !== 16'h0000) begin n_bad++; $display("FAIL clr_lost start %0d: got %h want 0000", start, count_bcd); end
    endtask

    task automatic test_scan();
        logic [3:0] sel_tab [4];
        sel_tab = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        do_reset();
        for (int k = 0; k < 24; k++) begin
            n_cmp++; if (digit_sel !== sel_tab[k / 3 % 4]) begin n_bad++; $display("FAIL scan_sel cyc %0d: got %b want %b", k, digit_sel, sel_tab[k / 3 % 4]); end
            n_cmp++; if (digit_bcd !== exp_digit(0, k)) begin n_bad++; $display("FAIL scan_zero_digit cyc %0d: got %h want %h", k, digit_bcd, exp_digit(0, k)); end
            @(negedge clk);
        end
        preload(4321);
        for (int k = 0; k < 24; k++) begin
            n_cmp++; if (digit_sel !== sel_tab[(m.t / S) % N]) begin n_bad++; $display("FAIL scan_sel2 cyc %0d: got %b want %b", k, digit_sel, sel_tab[(m.t / S) % N]); end
            n_cmp++; if (digit_bcd !== exp_digit(m.count, m.t)) begin n_bad++; $display("FAIL scan_digit cyc %0d: got %h want %h", k, digit_bcd, exp_digit(m.count, m.t)); end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_debounce();
        int guard = 0;
        do_reset();
        preload(5);
        btn_raw = 1'b1;
        while (m.run != 3 && guard < 30) begin
            @(negedge clk);
            guard++;
        end
        n_cmp++; if (m.run != 3) begin n_bad++; $display("FAIL midrst_reach: got run %0d want 3", m.run); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (count_bcd !== 16'h0000) begin n_bad++; $display("FAIL midrst_count: got %h want 0000", count_bcd); end
        n_cmp++; if (digit_bcd !== 4'h0) begin n_bad++; $display("FAIL midrst_digit: got %h want 0", digit_bcd); end
        n_cmp++; if (digit_sel !== 4'b1110) begin n_bad++; $display("FAIL midrst_sel: got %b want 1110", digit_sel); end
        n_cmp++; if (press_pulse !== 1'b0) begin n_bad++; $display("FAIL midrst_pulse: got %b want 0", press_pulse); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL midrst_ovf: got %b want 0", overflow); end
        btn_raw = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            n_cmp++; if (press_pulse !== 1'b0) begin n_bad++; $display("FAIL midrst_ghost cyc %0d: got %b want 0", k, press_pulse); end
        end
        n_cmp++; if (count_bcd !== 16'h0000) begin n_bad++; $display("FAIL midrst_after: got %h want 0000", count_bcd); end
    endtask

    task automatic test_blank();
        logic [3:0] tab [4];
`ifdef LEADING_ZERO_BLANK_EN
        tab = '{4'h7, 4'hF, 4'hF, 4'hF};
`else
        tab = '{4'h7, 4'h0, 4'h0, 4'h0};
`endif
        do_reset();
        preload(7);
        for (int k = 0; k < 12; k++) begin
            n_cmp++; if (digit_bcd !== tab[(m.t / S) % N]) begin n_bad++; $display("FAIL blank_digit cyc %0d: got %h want %h", k, digit_bcd, tab[(m.t / S) % N]); end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        int hold = 0;
        do_reset();
        preload(9995);
        for (int k = 0; k < 800; k++) begin
            if (hold == 0) begin
                btn_raw = 1'($urandom_range(0, 1));
                hold    = $urandom_range(1, 2 * D + 2);
            end
            hold--;
            clr = ($urandom_range(0, 399) == 0);
            @(negedge clk);
            n_cmp++; if (press_pulse !== m.pulse) begin n_bad++; $display("FAIL rand_pulse cyc %0d: got %b want %b", k, press_pulse, m.pulse); end
            n_cmp++; if (overflow !== m.ov) begin n_bad++; $display("FAIL rand_ovf cyc %0d: got %b want %b", k, overflow, m.ov); end
            n_cmp++; if (count_bcd !== exp_bcd(m.count)) begin n_bad++; $display("FAIL rand_count cyc %0d: got %h want %h", k, count_bcd, exp_bcd(m.count)); end
            n_cmp++; if (digit_sel !== exp_sel(m.t)) begin n_bad++; $display("FAIL rand_sel cyc %0d: got %b want %b", k, digit_sel, exp_sel(m.t)); end
            n_cmp++; if (digit_bcd !== exp_digit(m.count, m.t)) begin n_bad++; $display("FAIL rand_digit cyc %0d: got %h want %h", k, digit_bcd, exp_digit(m.count, m.t)); end
        end
        clr     = 1'b0;
        btn_raw = 1'b0;
    endtask

    initial begin
        test_reset();
        test_glitch_press();
        test_hold_through_reset();
        test_wrap();
        test_carry();
        test_clr_priority(42);
        test_clr_priority(9999);
        test_scan();
        test_reset_mid_debounce();
        test_blank();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
